// File: rtl/sigmoid_backprop_pkg.sv
// sigmoid_backprop_pkg: float constants, FSM encoding and the FP arithmetic shared by the units.
package sigmoid_backprop_pkg;
  localparam logic [31:0] ONE = 32'h3F800000;
  localparam logic [31:0] TWO = 32'h40000000;
  localparam logic [31:0] HALF = 32'h3F000000;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  typedef enum logic [2:0] {IDLE, ADD, DIV1, DIV2, DIV3, DONE} state_t;
  // m carries hidden bit at [26] plus guard/round/sticky in [2:0]; rounds to nearest even
  function automatic logic [31:0] fp_pack(input logic s, input logic signed [9:0] e, input logic [26:0] m);
    logic signed [9:0] ee;
    logic [26:0] mm;
    logic [24:0] r;
    logic [9:0] sh;
    ee = e;
    mm = m;
    if (ee < 10'sd1) begin
      sh = 10'sd1 - ee;
      mm = (sh > 10'd26) ? {26'b0, |m} : (m >> sh) | {26'b0, |(m & ~(27'h7FFFFFF << sh))};
      ee = 10'sd1;
    end
    r = {1'b0, mm[26:3]} + {24'b0, mm[2] & (mm[1] | mm[0] | mm[3])};
    if (r[24]) begin
      r = r >> 1;
      ee = ee + 10'sd1;
    end
    return (ee >= 10'sd255) ? {s, 8'hFF, 23'b0} : {s, r[23] ? ee[7:0] : 8'h00, r[22:0]};
  endfunction
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hi, lo;
    logic [27:0] mh, ml, sum;
    logic [7:0] eh, el, d;
    logic signed [9:0] e;
    logic a_nan, b_nan, a_inf, b_inf;
    a_nan = &a[30:23] && |a[22:0];
    b_nan = &b[30:23] && |b[22:0];
    a_inf = &a[30:23] && !(|a[22:0]);
    b_inf = &b[30:23] && !(|b[22:0]);
    if (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31])) return QNAN;
    if (a_inf) return a;
    if (b_inf) return b;
    {hi, lo} = (a[30:0] < b[30:0]) ? {b, a} : {a, b};
    eh = (hi[30:23] == 8'd0) ? 8'd1 : hi[30:23];
    el = (lo[30:23] == 8'd0) ? 8'd1 : lo[30:23];
    d = eh - el;
    e = $signed({2'b0, eh});
    mh = {1'b0, |hi[30:23], hi[22:0], 3'b0};
    ml = {1'b0, |lo[30:23], lo[22:0], 3'b0};
    ml = (d > 8'd27) ? {27'b0, |ml} : (ml >> d) | {27'b0, |(ml & ~(28'hFFFFFFF << d))};
    sum = (hi[31] == lo[31]) ? mh + ml : mh - ml;
    if (sum == 28'd0) return {hi[31] & lo[31], 31'b0};
    if (sum[27]) return fp_pack(hi[31], e + 10'sd1, {sum[27:2], |sum[1:0]});
    for (int i = 0; i < 26; i++)
      if (!sum[26] && e > 10'sd1) begin
        sum = sum << 1;
        e = e - 10'sd1;
      end
    return fp_pack(hi[31], e, sum[26:0]);
  endfunction
  function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
    logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [23:0] ma, mb, rem;
    logic signed [9:0] ea, eb, e;
    logic [27:0] q;
    logic [26:0] m;
    s = a[31] ^ b[31];
    a_nan = &a[30:23] && |a[22:0];
    b_nan = &b[30:23] && |b[22:0];
    a_inf = &a[30:23] && !(|a[22:0]);
    b_inf = &b[30:23] && !(|b[22:0]);
    a_zero = a[30:0] == 31'd0;
    b_zero = b[30:0] == 31'd0;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) return QNAN;
    if (a_inf || b_zero) return {s, 8'hFF, 23'b0};
    if (b_inf || a_zero) return {s, 31'b0};
    ma = {|a[30:23], a[22:0]};
    mb = {|b[30:23], b[22:0]};
    ea = (a[30:23] == 8'd0) ? 10'sd1 : $signed({2'b0, a[30:23]});
    eb = (b[30:23] == 8'd0) ? 10'sd1 : $signed({2'b0, b[30:23]});
    for (int i = 0; i < 23; i++) begin
      if (!ma[23]) begin
        ma = ma << 1;
        ea = ea - 10'sd1;
      end
      if (!mb[23]) begin
        mb = mb << 1;
        eb = eb - 10'sd1;
      end
    end
    q = 28'({ma, 27'b0} / {27'b0, mb});
    rem = 24'({ma, 27'b0} % {27'b0, mb});
    e = ea - eb + 10'sd127;
    if (q[27]) m = {q[27:2], |q[1:0] | (rem != 24'd0)};
    else begin
      m = {q[26:1], q[0] | (rem != 24'd0)};
      e = e - 10'sd1;
    end
    return fp_pack(s, e, m);
  endfunction
endpackage

// File: rtl/Fadder_Fsubtractor.sv
// Fadder_Fsubtractor: single-precision add/sub; result register loads when en is high.
module Fadder_Fsubtractor
  import sigmoid_backprop_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0] y_d, y_q;
  always_comb y_d = en ? fp_add(a, {b[31] ^ sub, b[30:0]}) : y_q;
  always_ff @(posedge clk) y_q <= reset_n ? y_d : 32'h0;
  assign y = y_q;
endmodule

// File: rtl/Fdivider.sv
// Fdivider: single-precision divide a/b; result register loads when en is high.
module Fdivider
  import sigmoid_backprop_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0] y_d, y_q;
  always_comb y_d = en ? fp_div(a, b) : y_q;
  always_ff @(posedge clk) y_q <= reset_n ? y_d : 32'h0;
  assign y = y_q;
endmodule

// File: rtl/sigmoid_backprop.sv
// sigmoid_backprop: grad = delta / (2*(|x|+1)^2) using one shared adder and one shared divider.
module sigmoid_backprop
  import sigmoid_backprop_pkg::*;
#(
  parameter int ADD_LAT = 1,
  parameter int DIV_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [31:0] delta,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] grad
);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] ax_q, ax_d, dl_q, dl_d, a_res, div_res, div_a, div_b;
  logic last, busy, add_en, div_en;
  // unit result registers double as stage results: a held by the adder, t/u/g by the divider
  always_comb begin
    last = cnt_q == 4'd1;
    busy = state_q inside {ADD, DIV1, DIV2, DIV3};
    add_en = state_q == ADD && last;
    div_en = busy && state_q != ADD && last;
    div_a = state_q == DIV1 ? dl_q : div_res;
    div_b = state_q == DIV3 ? TWO : a_res;
    state_d = state_q;
    cnt_d = cnt_q;
    ax_d = ax_q;
    dl_d = dl_q;
    if (state_q == IDLE && in_valid) begin
      state_d = ADD;
      cnt_d = 4'(ADD_LAT);
      ax_d = x & 32'h7FFFFFFF;
      dl_d = delta;
    end else if (busy) begin
      state_d = last ? state_t'(state_q + 3'd1) : state_q;
      cnt_d = !last ? cnt_q - 4'd1 : state_q == DIV3 ? 4'd0 : 4'(DIV_LAT);
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      ax_q <= 32'h0;
      dl_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ax_q <= ax_d;
      dl_q <= dl_d;
    end
  end
  Fadder_Fsubtractor u_add (
    .clk(clk),
    .reset_n(~reset),
    .en(add_en),
    .sub(1'b0),
    .a(ONE),
    .b(ax_q),
    .y(a_res)
  );
  Fdivider u_div (
    .clk(clk),
    .reset_n(~reset),
    .en(div_en),
    .a(div_a),
    .b(div_b),
    .y(div_res)
  );
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign grad = div_res;
endmodule
